// File: rtl/fnd_display_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_display_ctrl
// Display-side consumer of the stopwatch/watch counters. Captures two 0..99
// binary pair values on a strobe, converts them to BCD with an iterative
// double-dabble engine and time-multiplexes a 4-digit common-anode FND.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> the leftmost (hi tens) digit is blanked when it is zero
//   undefined -> all four digits are always lit, leading zeros included
// -----------------------------------------------------------------------------
module fnd_display_ctrl #(
    parameter int         SCAN_DIV = 100_000,  // clocks per digit slot, >= 2
    parameter logic [6:0] SAT_VAL  = 7'd99     // substitute for inputs > 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] i_hi,
    input  logic [6:0] i_lo,
    input  logic       i_valid,
    input  logic       i_dot,
    output logic       o_busy,
    output logic       o_sat,
    output logic [3:0] o_fnd_comm,
    output logic [7:0] o_fnd_font
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int            PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    // Seven shifts for a 7-bit value; the counter runs 0..6.
    localparam logic [2:0] LAST_SHIFT = 3'd6;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Saturate an input pair value to the largest displayable number.
    function automatic logic [6:0] clamp_val(input logic [6:0] v);
        logic [6:0] r;
        if (v > 7'd99) begin
            r = SAT_VAL;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Flag an input value that cannot be shown on two digits.
    function automatic logic over_range(input logic [6:0] v);
        return (v > 7'd99);
    endfunction

    // One double-dabble step: correct nibbles >= 5 by +3, then shift left.
    // Returns {bcd[7:0], bin[6:0]} after the step.
    function automatic logic [14:0] dd_step(input logic [7:0] bcd,
                                            input logic [6:0] bin);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) begin
            adj[3:0] = adj[3:0] + 4'd3;
        end else begin
            adj[3:0] = adj[3:0];
        end
        if (adj[7:4] >= 4'd5) begin
            adj[7:4] = adj[7:4] + 4'd3;
        end else begin
            adj[7:4] = adj[7:4];
        end
        return {adj[6:0], bin, 1'b0};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for a BCD digit.
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic          r_pend;
    logic [6:0]    r_pend_hi;
    logic [6:0]    r_pend_lo;
    logic [6:0]    r_bin_hi;
    logic [6:0]    r_bin_lo;
    logic [7:0]    r_bcd_hi;
    logic [7:0]    r_bcd_lo;
    logic [2:0]    r_cnt;
    logic [7:0]    r_dig_hi;
    logic [7:0]    r_dig_lo;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic          r_busy;
    logic          r_sat;
    logic [3:0]    r_comm;
    logic [7:0]    r_font;

    logic          w_capture;
    logic [6:0]    w_src_hi;
    logic [6:0]    w_src_lo;
    logic [14:0]   w_step_hi;
    logic [14:0]   w_step_lo;
    logic [7:0]    w_dig_hi;
    logic [7:0]    w_dig_lo;
    logic [1:0]    w_idx_next;
    logic [3:0]    w_nib;
    logic          w_dp;
    logic [6:0]    w_seg;
    logic [3:0]    w_comm_next;
    logic [7:0]    w_font_next;

    // Capture decision: a fresh strobe beats an older pending value.
    always_comb begin
        w_capture = 1'b0;
        w_src_hi  = r_pend_hi;
        w_src_lo  = r_pend_lo;
        if (r_state == ST_IDLE) begin
            w_capture = i_valid | r_pend;
        end else begin
            w_capture = 1'b0;
        end
        if (i_valid) begin
            w_src_hi = i_hi;
            w_src_lo = i_lo;
        end else begin
            w_src_hi = r_pend_hi;
            w_src_lo = r_pend_lo;
        end
    end

    // Next double-dabble step for both pairs in parallel.
    always_comb begin
        w_step_hi = dd_step(r_bcd_hi, r_bin_hi);
        w_step_lo = dd_step(r_bcd_lo, r_bin_lo);
    end

    // Capture FSM: IDLE -> CONV (7 shifts) -> LOAD -> IDLE, with a 1-deep pending slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pend    <= 1'b0;
            r_pend_hi <= 7'd0;
            r_pend_lo <= 7'd0;
            r_bin_hi  <= 7'd0;
            r_bin_lo  <= 7'd0;
            r_bcd_hi  <= 8'd0;
            r_bcd_lo  <= 8'd0;
            r_cnt     <= 3'd0;
            r_dig_hi  <= 8'd0;
            r_dig_lo  <= 8'd0;
            r_busy    <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            // Busy covers the capture edge through the LOAD edge.
            r_busy <= w_capture | (r_state != ST_IDLE);

            // Strobes arriving while the engine is working park in the pending slot.
            if ((r_state != ST_IDLE) && i_valid) begin
                r_pend    <= 1'b1;
                r_pend_hi <= i_hi;
                r_pend_lo <= i_lo;
            end else if (w_capture) begin
                r_pend    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_bin_hi <= clamp_val(w_src_hi);
                        r_bin_lo <= clamp_val(w_src_lo);
                        r_bcd_hi <= 8'd0;
                        r_bcd_lo <= 8'd0;
                        r_cnt    <= 3'd0;
                        r_sat    <= over_range(w_src_hi) | over_range(w_src_lo);
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {r_bcd_hi, r_bin_hi} <= w_step_hi;
                    {r_bcd_lo, r_bin_lo} <= w_step_lo;
                    if (r_cnt == LAST_SHIFT) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_LOAD: begin
                    r_dig_hi <= r_bcd_hi;
                    r_dig_lo <= r_bcd_lo;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Digit values seen by the next slot: a LOAD on the same edge wins.
    always_comb begin
        w_dig_hi = r_dig_hi;
        w_dig_lo = r_dig_lo;
        if (r_state == ST_LOAD) begin
            w_dig_hi = r_bcd_hi;
            w_dig_lo = r_bcd_lo;
        end else begin
            w_dig_hi = r_dig_hi;
            w_dig_lo = r_dig_lo;
        end
    end

    // Select the digit, decimal point and enable for the upcoming slot.
    always_comb begin
        w_idx_next  = r_idx + 2'd1;
        w_nib       = 4'd0;
        w_dp        = 1'b1;
        w_comm_next = 4'b1110;
        case (w_idx_next)
            2'd0: begin
                w_nib       = w_dig_lo[3:0];
                w_comm_next = 4'b1110;
            end
            2'd1: begin
                w_nib       = w_dig_lo[7:4];
                w_comm_next = 4'b1101;
            end
            2'd2: begin
                w_nib       = w_dig_hi[3:0];
                w_dp        = ~i_dot;
                w_comm_next = 4'b1011;
            end
            2'd3: begin
                w_nib       = w_dig_hi[7:4];
                w_comm_next = 4'b0111;
            end
            default: begin
                w_nib       = 4'd0;
                w_comm_next = 4'b1110;
            end
        endcase
        w_seg = seg_of(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
        if ((w_idx_next == 2'd3) && (w_nib == 4'd0)) begin
            w_seg = 7'h7F;
        end else begin
            w_seg = seg_of(w_nib);
        end
`endif
        w_font_next = {w_dp, w_seg};
    end

    // Scan prescaler; enables and segments are registered together at slot boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= PRESC_ZERO;
            r_idx   <= 2'd0;
            r_comm  <= 4'b1110;
            r_font  <= 8'hC0;
        end else begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= PRESC_ZERO;
                r_idx   <= w_idx_next;
                r_comm  <= w_comm_next;
                r_font  <= w_font_next;
            end else begin
                r_presc <= r_presc + PRESC_ONE;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_sat      = r_sat;
    assign o_fnd_comm = r_comm;
    assign o_fnd_font = r_font;

endmodule
